// File: rtl/load_unit.sv
// load_unit: byte/half/word load engine with sign/zero extension.
// Optional macro LOAD_MISALIGNED_EN lets word-crossing loads proceed as two reads.
// Without it, those loads are reported as errors.
module load_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BYTE_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH-1:0] A,
    output logic                     mem_re,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    RD,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic                     rsp_err
);

    localparam int unsigned WORD_AW   = ADDRESS_WIDTH - 2;
    localparam int unsigned HALF_W    = 2 * BYTE_WIDTH;
    localparam int unsigned PAIR_W    = 2 * DATA_WIDTH;
`ifdef LOAD_MISALIGNED_EN
    localparam bit          MISALIGNED_EN = 1'b1;
`else
    localparam bit          MISALIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

    // Access spills into the next word (half at offset 3, word at any non-zero offset)
    function automatic logic is_crossing(input logic [2:0] f, input logic [1:0] off);
        case (f)
            3'b001, 3'b101: is_crossing = (off == 2'b11);
            3'b010:         is_crossing = (off != 2'b00);
            default:        is_crossing = 1'b0;
        endcase
    endfunction

    // Known encoding, and crossing allowed only when two-read support is built in
    function automatic logic is_legal(input logic [2:0] f, input logic [1:0] off);
        logic known;
        known = (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
                (f == 3'b100) || (f == 3'b101);
        is_legal = known && (MISALIGNED_EN || !is_crossing(f, off));
    endfunction

    // Align the {word1,word0} pair by byte offset, then extend byte/half to full width
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [PAIR_W-1:0] pair,
                                                      input logic [1:0]        off,
                                                      input logic [2:0]        f);
        logic [DATA_WIDTH-1:0] sh;
        logic                  sgn;
        sh = DATA_WIDTH'(pair >> (32'(off) * BYTE_WIDTH));
        case (f[1:0])
            2'b00: begin
                sgn     = ~f[2] & sh[BYTE_WIDTH-1];
                extract = {{(DATA_WIDTH-BYTE_WIDTH){sgn}}, sh[BYTE_WIDTH-1:0]};
            end
            2'b01: begin
                sgn     = ~f[2] & sh[HALF_W-1];
                extract = {{(DATA_WIDTH-HALF_W){sgn}}, sh[HALF_W-1:0]};
            end
            default: begin
                sgn     = 1'b0;
                extract = sh;
            end
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic [WORD_AW-1:0]      waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   word0_q, word0_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    // Next-state, datapath capture and combinational memory strobe
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        waddr_d   = waddr_q;
        word0_d   = word0_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = {waddr_q, 2'b00};

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d = funct3;
                    off_d    = A[1:0];
                    waddr_d  = A[ADDRESS_WIDTH-1:2];
                    if (is_legal(funct3, A[1:0])) begin
                        mem_re   = 1'b1;
                        mem_addr = {A[ADDRESS_WIDTH-1:2], 2'b00};
                        state_d  = RD0;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RD0: begin
                word0_d = RD;
                if (MISALIGNED_EN && is_crossing(funct3_q, off_q)) begin
                    waddr_d  = WORD_AW'(waddr_q + 1'b1);
                    mem_re   = 1'b1;
                    mem_addr = {WORD_AW'(waddr_q + 1'b1), 2'b00};
                    state_d  = RD1;
                end else begin
                    rdata_d = extract({DATA_WIDTH'(0), RD}, off_q, funct3_q);
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RD1: begin
                rdata_d = extract({RD, word0_q}, off_q, funct3_q);
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            state_d   = IDLE;
            rdata_d   = '0;
            err_d     = 1'b0;
            req_ready = 1'b0;
            mem_re    = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        funct3_q <= funct3_d;
        off_q    <= off_d;
        waddr_q  <= waddr_d;
        word0_q  <= word0_d;
        rdata_q  <= rdata_d;
        err_q    <= err_d;
    end

    assign rsp_valid = (state_q == RESP) && !rst;
    assign RDATA     = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit with a one-cycle-latency memory model.
module tb_load_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [8:0]  A;
    logic        mem_re;
    logic [8:0]  mem_addr;
    logic [31:0] RD;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] RDATA;
    logic        rsp_err;

    logic [31:0] mem [128];
    int          n_tests = 0;
    int          n_fail  = 0;

    load_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .A         (A),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .RD        (RD),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .RDATA     (RDATA),
        .rsp_err   (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns the addressed word the cycle after the strobe
    always @(posedge clk) begin
        if (mem_re) RD <= mem[mem_addr[8:2]];
    end

    // Issue one load with rsp_ready high and record what the unit does
    task automatic do_load(input logic [2:0] f, input logic [8:0] a,
                           output int lat, output int nre,
                           output logic [8:0] addr0, output logic [8:0] addr1,
                           output logic [31:0] data, output logic err);
        lat = 0; nre = 0; addr0 = '0; addr1 = '0; data = 'x; err = 1'bx;
        @(negedge clk);
        funct3 = f; A = a; req_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        if (mem_re) begin addr0 = mem_addr; nre = 1; end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (mem_re) begin
                if (nre == 0) addr0 = mem_addr; else addr1 = mem_addr;
                nre++;
            end
            if (rsp_valid) begin
                lat = i; data = RDATA; err = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        n_tests++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re got %b exp 0", mem_re); end
        n_tests++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", RDATA); end
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", rsp_err); end
        rst = 1'b0;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_aligned;
        logic [2:0]  f  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001};
        logic [8:0]  ad [6] = '{9'h000, 9'h000, 9'h002, 9'h002, 9'h000, 9'h001};
        logic [31:0] ex [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFDDCC,
                                32'h0000DDCC, 32'hDDCCBBAA, 32'hFFFFCCBB};
        int lat, nre; logic [8:0] a0, a1; logic [31:0] d; logic e;
        for (int i = 0; i < 6; i++) begin
            do_load(f[i], ad[i], lat, nre, a0, a1, d, e);
            n_tests++; if (d !== ex[i]) begin n_fail++; $display("FAIL aligned%0d_data got %h exp %h", i, d, ex[i]); end
            n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL aligned%0d_err got %b exp 0", i, e); end
            n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL aligned%0d_latency got %0d exp 2", i, lat); end
            n_tests++; if (nre !== 1) begin n_fail++; $display("FAIL aligned%0d_mem_re_count got %0d exp 1", i, nre); end
            n_tests++; if (a0 !== {ad[i][8:2], 2'b00}) begin n_fail++; $display("FAIL aligned%0d_addr got %h exp %h", i, a0, {ad[i][8:2], 2'b00}); end
        end
    endtask

    task automatic test_crossing;
        int lat, nre; logic [8:0] a0, a1; logic [31:0] d; logic e;
`ifdef LOAD_MISALIGNED_EN
        logic [2:0]  f  [3] = '{3'b010, 3'b001, 3'b010};
        logic [8:0]  ad [3] = '{9'h001, 9'h003, 9'h1FD};
        logic [31:0] ex [3] = '{32'h11DDCCBB, 32'h000011DD, 32'hAA876543};
        logic [8:0]  e0 [3] = '{9'h000, 9'h000, 9'h1FC};
        logic [8:0]  e1 [3] = '{9'h004, 9'h004, 9'h000};
        for (int i = 0; i < 3; i++) begin
            do_load(f[i], ad[i], lat, nre, a0, a1, d, e);
            n_tests++; if (d !== ex[i]) begin n_fail++; $display("FAIL cross%0d_data got %h exp %h", i, d, ex[i]); end
            n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL cross%0d_err got %b exp 0", i, e); end
            n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL cross%0d_latency got %0d exp 3", i, lat); end
            n_tests++; if (nre !== 2) begin n_fail++; $display("FAIL cross%0d_mem_re_count got %0d exp 2", i, nre); end
            n_tests++; if (a0 !== e0[i]) begin n_fail++; $display("FAIL cross%0d_addr0 got %h exp %h", i, a0, e0[i]); end
            n_tests++; if (a1 !== e1[i]) begin n_fail++; $display("FAIL cross%0d_addr1 got %h exp %h", i, a1, e1[i]); end
        end
`else
        logic [2:0] f  [2] = '{3'b010, 3'b001};
        logic [8:0] ad [2] = '{9'h001, 9'h003};
        for (int i = 0; i < 2; i++) begin
            do_load(f[i], ad[i], lat, nre, a0, a1, d, e);
            n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL cross%0d_err got %b exp 1", i, e); end
            n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL cross%0d_data got %h exp 0", i, d); end
            n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL cross%0d_latency got %0d exp 1", i, lat); end
            n_tests++; if (nre !== 0) begin n_fail++; $display("FAIL cross%0d_mem_re_count got %0d exp 0", i, nre); end
        end
`endif
    endtask

    task automatic test_illegal;
        logic [2:0] f [3] = '{3'b011, 3'b110, 3'b111};
        int lat, nre; logic [8:0] a0, a1; logic [31:0] d; logic e;
        for (int i = 0; i < 3; i++) begin
            do_load(f[i], 9'h004, lat, nre, a0, a1, d, e);
            n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_err got %b exp 1", i, e); end
            n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL illegal%0d_data got %h exp 0", i, d); end
            n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL illegal%0d_latency got %0d exp 1", i, lat); end
            n_tests++; if (nre !== 0) begin n_fail++; $display("FAIL illegal%0d_mem_re_count got %0d exp 0", i, nre); end
        end
        // A legal load right after an error must carry a clean status
        do_load(3'b010, 9'h004, lat, nre, a0, a1, d, e);
        n_tests++; if (d !== 32'h44332211) begin n_fail++; $display("FAIL after_err_data got %h exp 44332211", d); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL after_err_err got %b exp 0", e); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        funct3 = 3'b010; A = 9'h004; req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            funct3 = 3'b000; A = 9'h000; req_valid = 1'b1;
            #1;
            n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_rsp_valid got %b exp 1", i, rsp_valid); end
            n_tests++; if (RDATA !== 32'h44332211) begin n_fail++; $display("FAIL bp%0d_rdata got %h exp 44332211", i, RDATA); end
            n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp%0d_err got %b exp 0", i, rsp_err); end
            n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_req_ready got %b exp 0", i, req_ready); end
            n_tests++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL bp%0d_mem_re got %b exp 0", i, mem_re); end
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid got %b exp 1", rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_queue%0d got %b exp 0", i, rsp_valid); end
            n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle%0d_req_ready got %b exp 1", i, req_ready); end
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
`ifdef LOAD_MISALIGNED_EN
        funct3 = 3'b010; A = 9'h001;
`else
        funct3 = 3'b010; A = 9'h000;
`endif
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LOAD_MISALIGNED_EN
        @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid got %b exp 0", rsp_valid); end
        n_tests++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_re got %b exp 0", mem_re); end
        rst = 1'b0;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready got %b exp 1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale%0d got %b exp 0", i, rsp_valid); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]   = 32'hDDCCBBAA;
        mem[1]   = 32'h44332211;
        mem[127] = 32'h87654321;
        RD = 32'h0; rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        funct3 = 3'b000; A = 9'h000;

        test_reset;
        test_aligned;
        test_crossing;
        test_illegal;
        test_backpressure;
        test_reset_midop;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
